// File: rtl/pll_mon_pkg.sv
// Shared types and default constants for the PLL clock monitor.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } pll_mon_state_t;

    localparam int DEF_GATE_CYCLES  = 27000;
    localparam int DEF_EXPECTED     = 10000;
    localparam int DEF_TOL          = 50;
    localparam int DEF_LOCK_WINDOWS = 4;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STUCK_CYCLES = 64;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain followed by the edge-history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pll_clk_monitor.sv
// Frequency and lock monitor for a PLL output clock.
// Counts synchronized rising edges of mon_clk over a fixed gate window and
// qualifies lock after LOCK_WINDOWS consecutive in-range windows.
// Optional no-edge (stuck clock) detection is built when PLL_MON_STUCK_EN
// is defined; otherwise stuck is tied low and a dead clock shows up only as
// an out-of-range window.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled; counters held at zero, locked low
// ACQUIRE | counting windows, waiting for LOCK_WINDOWS good ones in a row
// LOCKED  | lock declared; a single bad window drops lock and sets fault
module pll_clk_monitor
    import pll_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int EXPECTED     = DEF_EXPECTED,
    parameter int TOL          = DEF_TOL,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic             clear_fault,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             fault,
    output logic             stuck
);

    localparam int GOOD_W = width_for(LOCK_WINDOWS);

    localparam logic [CNT_W-1:0]  GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    RANGE_LO  = (CNT_W + 1)'(EXPECTED - TOL);
    localparam logic [CNT_W:0]    RANGE_HI  = (CNT_W + 1)'(EXPECTED + TOL);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);

    pll_mon_state_t    state_q;
    pll_mon_state_t    state_d;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_d;
    logic              locked_q;
    logic              locked_d;
    logic              fault_q;
    logic              fault_d;
    logic              fault_set;

    logic              mon_rise;
    logic [CNT_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  win_count;
    logic              win_ok;
    logic              win_end;
    logic              win_eval;
    logic              run;
    logic              stuck_hit;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (mon_clk),
        .rise     (mon_rise)
    );

    // Counting is live only outside IDLE and while enable holds; dropping
    // enable discards the partial window in the same cycle.
    assign run = (state_q != IDLE) && enable;

    assign win_end  = (gate_cnt == GATE_LAST);
    // An edge arriving on the terminal cycle still belongs to this window.
    assign win_count = (mon_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign win_ok    = ({1'b0, win_count} >= RANGE_LO) && ({1'b0, win_count} <= RANGE_HI);
    assign win_eval  = run && win_end && !stuck_hit;

`ifdef PLL_MON_STUCK_EN
    localparam int QUIET_W = width_for(STUCK_CYCLES);
    localparam logic [QUIET_W-1:0] QUIET_LOAD = QUIET_W'(STUCK_CYCLES - 1);

    logic [QUIET_W-1:0] quiet_cnt;
    logic               stuck_q;

    assign stuck_hit = run && !mon_rise && (quiet_cnt == '0);

    // No-edge down-counter; terminal count flags a stuck clock and reloads
    // so a dead input keeps aborting windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            quiet_cnt <= QUIET_LOAD;
            stuck_q   <= 1'b0;
        end else begin
            if (!run || mon_rise || (quiet_cnt == '0)) begin
                quiet_cnt <= QUIET_LOAD;
            end else begin
                quiet_cnt <= quiet_cnt - QUIET_W'(1);
            end
            if (mon_rise) begin
                stuck_q <= 1'b0;
            end else if (stuck_hit) begin
                stuck_q <= 1'b1;
            end
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck_hit = 1'b0;
    assign stuck     = 1'b0;
`endif

    // Gate and edge counters plus the per-window result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (!run || stuck_hit) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (win_end) begin
                gate_cnt    <= '0;
                edge_cnt    <= '0;
                count       <= win_count;
                count_valid <= 1'b1;
                in_range    <= win_ok;
            end else begin
                gate_cnt <= gate_cnt + CNT_W'(1);
                edge_cnt <= win_count;
            end
        end
    end

    // Lock state machine: next state, good-window count, lock and fault.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        locked_d  = locked_q;
        fault_set = 1'b0;

        case (state_q)
            IDLE: begin
                good_d   = '0;
                locked_d = 1'b0;
                if (enable) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (win_eval) begin
                    if (!win_ok) begin
                        good_d = '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        good_d   = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (win_eval && !win_ok) begin
                    state_d   = ACQUIRE;
                    locked_d  = 1'b0;
                    good_d    = '0;
                    fault_set = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                good_d   = '0;
                locked_d = 1'b0;
            end
        endcase

        if (stuck_hit) begin
            state_d  = ACQUIRE;
            good_d   = '0;
            locked_d = 1'b0;
            if (state_q == LOCKED) begin
                fault_set = 1'b1;
            end
        end

        if (!enable) begin
            state_d   = IDLE;
            good_d    = '0;
            locked_d  = 1'b0;
            fault_set = 1'b0;
        end

        // A new fault beats a simultaneous clear request.
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (clear_fault) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign locked = locked_q;
    assign fault  = fault_q;

endmodule
